simon_sequencer: RTL

SIMON_SEQUENCER -- requirements
Module: simon_sequencer

---
 rtl/simon_pkg.sv | 26 ++
 rtl/simon_sequencer_if.sv | 25 ++
 rtl/simon_seq_mem.sv | 33 +++
 rtl/simon_sequencer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types and default constants for the Simon sequencer.
package simon_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_APPEND   = 3'd1,
    S_SHOW_ON  = 3'd2,
    S_SHOW_OFF = 3'd3,
    S_WAIT_IN  = 3'd4,
    S_OVER     = 3'd5
  } state_t;

  typedef logic [1:0] move_t;

  localparam int SEQ_MAX_DEF   = 16;
  localparam int ON_TICKS_DEF  = 30;
  localparam int OFF_TICKS_DEF = 30;
  localparam int TIMEOUT_DEF   = 120;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/simon_sequencer_if.sv
// Game-side bus of the Simon sequencer: random source, player keys and display outputs.
interface simon_sequencer_if;
  import simon_pkg::*;

  move_t       rand_in;
  logic        start;
  move_t       player_num;
  logic        player_pressed;
  logic        simon_turn;
  move_t       simon_num;
  logic        simon_pressed;
  logic [4:0]  seq_len;
  logic        game_over;
  logic        win;

  modport master (
    output rand_in, start, player_num, player_pressed,
    input  simon_turn, simon_num, simon_pressed, seq_len, game_over, win
  );

  modport slave (
    input  rand_in, start, player_num, player_pressed,
    output simon_turn, simon_num, simon_pressed, seq_len, game_over, win
  );
endinterface

// File: rtl/simon_seq_mem.sv
// Move storage: one synchronous write port, one combinational read port.
module simon_seq_mem
  import simon_pkg::*;
#(
  parameter int DEPTH = SEQ_MAX_DEF
) (
  input  logic       clk,
  input  logic       i_wr_en,
  input  logic [4:0] i_wr_addr,
  input  move_t      i_wr_data,
  input  logic [4:0] i_rd_addr,
  output move_t      o_rd_data
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  move_t r_mem [DEPTH];

  // Write port; contents deliberately survive a new game.
  always_ff @(posedge clk) begin
    if (i_wr_en && (i_wr_addr < 5'(DEPTH))) begin
      r_mem[i_wr_addr[AW-1:0]] <= i_wr_data;
    end
  end

  // Read port; out-of-range addresses return a harmless zero.
  always_comb begin
    if (i_rd_addr < 5'(DEPTH)) begin
      o_rd_data = r_mem[i_rd_addr[AW-1:0]];
    end else begin
      o_rd_data = 2'd0;
    end
  end
endmodule

// File: rtl/simon_sequencer.sv
// Simon game sequencer FSM. Define SIMON_TIMEOUT_EN to make an idle player lose
// after TIMEOUT cycles; otherwise the game waits for input indefinitely.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int SEQ_MAX   = SEQ_MAX_DEF,
  parameter int ON_TICKS  = ON_TICKS_DEF,
  parameter int OFF_TICKS = OFF_TICKS_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           reset,
  simon_sequencer_if.slave bus
);
  localparam int TMAX = max3(ON_TICKS, OFF_TICKS, TIMEOUT);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_t        r_state;
  logic [4:0]    r_seq_len;
  logic [4:0]    r_idx;
  logic [TW-1:0] r_timer;
  logic          r_simon_turn;
  move_t         r_simon_num;
  logic          r_simon_pressed;
  logic          r_game_over;
  logic          r_win;

  logic [4:0]    w_rd_addr;
  move_t         w_rd_data;
  logic          w_wr_en;
  logic          w_last;

  assign w_wr_en = (r_state == S_APPEND);
  assign w_last  = (r_idx == (r_seq_len - 5'd1));

  // Look ahead one move while in SHOW_OFF so the next SHOW_ON shows it on entry.
  always_comb begin
    w_rd_addr = 5'd0;
    case (r_state)
      S_SHOW_OFF: w_rd_addr = r_idx + 5'd1;
      S_WAIT_IN:  w_rd_addr = r_idx;
      default:    w_rd_addr = 5'd0;
    endcase
  end

  simon_seq_mem #(.DEPTH(SEQ_MAX)) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_seq_len),
    .i_wr_data (bus.rand_in),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Game FSM with all outputs registered on the transition into each state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_seq_len       <= 5'd0;
      r_idx           <= 5'd0;
      r_timer         <= {TW{1'b0}};
      r_simon_turn    <= 1'b0;
      r_simon_num     <= 2'd0;
      r_simon_pressed <= 1'b0;
      r_game_over     <= 1'b0;
      r_win           <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_OVER: begin
          if (bus.start) begin
            r_seq_len    <= 5'd0;
            r_idx        <= 5'd0;
            r_timer      <= {TW{1'b0}};
            r_win        <= 1'b0;
            r_game_over  <= 1'b0;
            r_simon_turn <= 1'b1;
            r_state      <= S_APPEND;
          end
        end
        S_APPEND: begin
          r_seq_len       <= r_seq_len + 5'd1;
          r_idx           <= 5'd0;
          r_timer         <= {TW{1'b0}};
          r_simon_pressed <= 1'b1;
          // On the first round mem[0] is being written this very edge.
          r_simon_num     <= (r_seq_len == 5'd0) ? bus.rand_in : w_rd_data;
          r_state         <= S_SHOW_ON;
        end
        S_SHOW_ON: begin
          if (r_timer == TW'(ON_TICKS - 1)) begin
            r_timer         <= {TW{1'b0}};
            r_simon_pressed <= 1'b0;
            r_state         <= S_SHOW_OFF;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_SHOW_OFF: begin
          if (r_timer == TW'(OFF_TICKS - 1)) begin
            r_timer <= {TW{1'b0}};
            if (w_last) begin
              r_idx        <= 5'd0;
              r_simon_turn <= 1'b0;
              r_simon_num  <= 2'd0;
              r_state      <= S_WAIT_IN;
            end else begin
              r_idx           <= r_idx + 5'd1;
              r_simon_pressed <= 1'b1;
              r_simon_num     <= w_rd_data;
              r_state         <= S_SHOW_ON;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_WAIT_IN: begin
          if (bus.player_pressed) begin
            r_timer <= {TW{1'b0}};
            if (bus.player_num != w_rd_data) begin
              r_game_over <= 1'b1;
              r_win       <= 1'b0;
              r_state     <= S_OVER;
            end else if (w_last && (r_seq_len == 5'(SEQ_MAX))) begin
              r_game_over <= 1'b1;
              r_win       <= 1'b1;
              r_state     <= S_OVER;
            end else if (w_last) begin
              r_simon_turn <= 1'b1;
              r_state      <= S_APPEND;
            end else begin
              r_idx <= r_idx + 5'd1;
            end
          end else begin
`ifdef SIMON_TIMEOUT_EN
            if (r_timer == TW'(TIMEOUT - 1)) begin
              r_game_over <= 1'b1;
              r_win       <= 1'b0;
              r_state     <= S_OVER;
            end else begin
              r_timer <= r_timer + TW'(1);
            end
`else
            r_timer <= {TW{1'b0}};
`endif
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.simon_turn    = r_simon_turn;
  assign bus.simon_num     = r_simon_num;
  assign bus.simon_pressed = r_simon_pressed;
  assign bus.seq_len       = r_seq_len;
  assign bus.game_over     = r_game_over;
  assign bus.win           = r_win;
endmodule
